inst_mem_ctrl: RTL
==================

INST_MEM_CTRL -- requirements
Module: inst_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 512, number of words; power of two, 64..4096.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; aligned to DEPTH*DATA_W/8.
REQ-004 SHALL have parameter BOOT_LOAD, default 1; 1 = leave reset in BOOT state, 0 = leave reset in RUN state.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port fetch_req  input  1  fetch request valid.
REQ-008 SHALL have port fetch_addr  input  32  fetch byte address.
REQ-009 SHALL have port fetch_ready  output  1  fetch request accepted this cycle when high with fetch_req.
REQ-010 SHALL have port rvalid  output  1  read response valid.
REQ-011 SHALL have port rdata  output  DATA_W  read response word.
REQ-012 SHALL have port rfault  output  1  response is a fault (misaligned or out of range).
REQ-013 SHALL have port rready  input  1  consumer accepts response.
REQ-014 SHALL have port ld_valid  input  1  load-write valid.
REQ-015 SHALL have port ld_addr  input  32  load byte address.
REQ-016 SHALL have port ld_data  input  DATA_W  load write data.
REQ-017 SHALL have port ld_wmask  input  DATA_W/8  byte write enables.
REQ-018 SHALL have port ld_done  input  1  single-cycle pulse ending boot load.
REQ-019 SHALL have port boot_busy  output  1  high in BOOT state.
REQ-020 SHALL have port ld_err  output  1  sticky: an out-of-range or misaligned load occurred.
REQ-021 SHALL have port ld_count  output  $clog2(DEPTH)+1  number of in-range loads accepted since reset, saturating.

Function
REQ-022 SHALL implement FSM states BOOT and RUN; BOOT->RUN on ld_done=1; RUN is terminal until reset; ld_done in RUN ignored.
REQ-023 SHALL hold fetch_ready=0 in BOOT; in RUN fetch_ready = !(rvalid && !rready).
REQ-024 SHALL accept loads every cycle in both states (no ld_ready); loads never stall fetches.
REQ-025 SHALL write word index (ld_addr-BASE_ADDR)>>log2(DATA_W/8) with only bytes whose ld_wmask bit is 1.
REQ-026 SHALL ignore a load whose address is misaligned or outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8), setting ld_err=1.
REQ-027 SHALL increment ld_count for each in-range aligned load with non-zero mask, saturating at all-ones.
REQ-028 SHALL return a response exactly 1 cycle after an accepted fetch: rvalid=1 next cycle; back-to-back fetches give one response per cycle.
REQ-029 SHALL hold rvalid, rdata, rfault stable while rvalid=1 and rready=0; a response is consumed on rvalid&&rready.
REQ-030 SHALL drop rvalid to 0 after consumption when no new fetch was accepted in the consuming cycle.
REQ-031 SHALL, for a fetch that is misaligned or out of range, return rfault=1 and rdata=NOP (32'h0000_0013, zero-extended for DATA_W=64) without reading the array.
REQ-032 SHALL, when a load and an accepted fetch hit the same word in the same cycle, return the post-write word (write-first forwarding, per byte mask).
REQ-033 SHALL use 32-bit unsigned address arithmetic for range checks; no wrap-around aliasing above the top word.

Reset
REQ-034 SHALL, on rst_n=0, asynchronously set state=BOOT if BOOT_LOAD=1 else RUN, rvalid=0, rdata=0, rfault=0, ld_err=0, ld_count=0.
REQ-035 SHALL not clear memory array contents on reset.
REQ-036 SHALL discard any in-flight response when reset asserts mid-operation; no rvalid after release until a new fetch.

Verification
REQ-037 Boot: reset, ld 0x0 data 0x00500093 mask 4'hF, ld_done, fetch 0x0 -> fetch_ready=0 before ld_done; rvalid next cycle, rdata=0x00500093, rfault=0, ld_count=1.
REQ-038 Backpressure: fetches 0x0,0x4,0x8 consecutive, rready=0 two cycles -> rdata of 0x0 held, fetch_ready=0; order 0x0,0x4,0x8 preserved on release.
REQ-039 Fault: fetch 0x2 and fetch 0x800 (DEPTH=512) -> rfault=1, rdata=0x00000013; ld to 0x800 -> ld_err=1, ld_count unchanged.
REQ-040 Forwarding: word 0x10=0xAAAAAAAA, same-cycle ld 0x10 data 0x11223344 mask 4'b0011 and fetch 0x10 -> rdata=0xAAAA3344.
REQ-041 Reset mid-stream: rst_n low while rvalid=1 -> rvalid=0 immediately, boot_busy=1; memory word previously loaded reads back unchanged after reboot.
REQ-042 Parameters: DATA_W=64, DEPTH=64, BOOT_LOAD=0 -> fetch accepted first cycle after reset; 65 loads -> ld_count saturates at 127 only after 127 loads.

Source files
------------

// File: rtl/inst_mem_ctrl.sv
// rtl/inst_mem_ctrl.sv - Boot-loadable instruction memory with single-cycle fetch response channel
module inst_mem_ctrl #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          BOOT_LOAD = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_req,
  input  logic [31:0]               fetch_addr,
  output logic                      fetch_ready,
  output logic                      rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rfault,
  input  logic                      rready,
  input  logic                      ld_valid,
  input  logic [31:0]               ld_addr,
  input  logic [DATA_W-1:0]         ld_data,
  input  logic [DATA_W/8-1:0]       ld_wmask,
  input  logic                      ld_done,
  output logic                      boot_busy,
  output logic                      ld_err,
  output logic [$clog2(DEPTH):0]    ld_count
);

  localparam int          WB        = DATA_W / 8;
  localparam int          SH        = $clog2(WB);
  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * WB);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [31:0]       ld_off, f_off;
  logic [AW-1:0]     ld_idx, f_idx;
  logic              ld_ok, f_ok, ld_hit, fetch_fire;
  logic [DATA_W-1:0] fwd_word;

  // The >= check keeps addresses below BASE_ADDR from wrapping into range.
  assign ld_off = ld_addr - BASE_ADDR;
  assign f_off  = fetch_addr - BASE_ADDR;
  assign ld_ok  = (ld_addr >= BASE_ADDR) && (ld_off < MEM_BYTES) && (ld_addr[SH-1:0] == '0);
  assign f_ok   = (fetch_addr >= BASE_ADDR) && (f_off < MEM_BYTES) && (fetch_addr[SH-1:0] == '0);
  assign ld_idx = ld_off[SH +: AW];
  assign f_idx  = f_off[SH +: AW];
  assign ld_hit = ld_valid && ld_ok;

  assign boot_busy   = (state == BOOT);
  assign fetch_ready = (state == RUN) && !(rvalid && !rready);
  assign fetch_fire  = fetch_req && fetch_ready;

  // Same-cycle load to the fetched word is merged byte-by-byte (write-first).
  always_comb begin
    fwd_word = mem[f_idx];
    if (ld_hit && (ld_idx == f_idx)) begin
      for (int b = 0; b < WB; b++) begin
        if (ld_wmask[b]) fwd_word[b*8 +: 8] = ld_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_hit) begin
      for (int b = 0; b < WB; b++) begin
        if (ld_wmask[b]) mem[ld_idx][b*8 +: 8] <= ld_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= (BOOT_LOAD != 0) ? BOOT : RUN;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rfault   <= 1'b0;
      ld_err   <= 1'b0;
      ld_count <= '0;
    end else begin
      if (state == BOOT && ld_done) state <= RUN;

      if (fetch_fire) begin
        rvalid <= 1'b1;
        rfault <= !f_ok;
        rdata  <= f_ok ? fwd_word : NOP;
      end else if (rready) begin
        rvalid <= 1'b0;
      end

      if (ld_valid && !ld_ok) ld_err <= 1'b1;
      if (ld_hit && (|ld_wmask) && (ld_count != '1)) ld_count <= ld_count + CW'(1);
    end
  end

endmodule
